pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 16-bit, 8-register, five-stage core.
//  Generates stall (enable), bubble and flush controls for:
//    - load-use hazards
//    - taken branches resolved in EX
//    - data-memory wait states, with timeout lock
//  Keeps saturating performance counters for stall and flush events.
// PARAMETERS
//  REG_ADDR_W   3   register address width
//  MEM_TIMEOUT  8   consecutive memory-freeze cycles before lock (>=2)
//  CNT_W        16  width of stall_count / flush_count
// PORTS
//  clk            in   1           clock; state/counters update on rising edge
//  rst            in   1           asynchronous reset, active-low
//  id_rs          in   REG_ADDR_W  source reg 1 of instruction in ID
//  id_rt          in   REG_ADDR_W  source reg 2 of instruction in ID
//  id_uses_rs     in   1           ID instruction reads id_rs
//  id_uses_rt     in   1           ID instruction reads id_rt
//  ex_rd          in   REG_ADDR_W  destination reg of instruction in EX
//  ex_memRead     in   1           EX instruction is a load
//  branch_taken   in   1           branch resolved taken in EX this cycle
//  mem_req        in   1           MEM stage access pending (memRead_mem|memWrite_mem)
//  mem_ready      in   1           data memory completes access this cycle
//  err_clr        in   1           clears LOCKED (ignored in other states)
//  pc_en          out  1           PC update enable
//  ifid_en        out  1           IF/ID load enable
//  ifid_flush     out  1           IF/ID loads NOP
//  idex_en        out  1           ID/EX load enable
//  idex_bubble    out  1           ID/EX loads zeroed controls
//  exmem_en       out  1           EX/MEM load enable
//  exmem_bubble   out  1           EX/MEM loads zeroed controls
//  mem_err        out  1           high in LOCKED
//  state          out  2           0=RUN 1=MEM_WAIT 2=LOCKED
//  stall_count    out  CNT_W       saturating stall-cycle counter
//  flush_count    out  CNT_W       saturating branch-flush counter
// BEHAVIOUR
//  Control outputs:
//  - Controls are combinational from state and inputs; they settle before the falling edge, where the pipeline registers capture.
//  - rst low (asynchronous): state=RUN, wait_cnt=0, counters=0, mem_err=0.
//  - While rst is low, all *_en=0 and ifid_flush=idex_bubble=exmem_bubble=1.
//  - Default (no event): all *_en=1, flush/bubbles=0.
//  Events, evaluated in RUN, or in MEM_WAIT with mem_ready=1:
//  - freeze   = mem_req & ~mem_ready
//  - load_use = ex_memRead & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
//  - All 3 address bits are compared; no register is exempt.
//  - Priority: freeze > branch_taken > load_use.
//  Event actions:
//  - freeze: all *_en=0, no bubbles, stall_count++.
//  - branch: pc_en=ifid_en=idex_en=exmem_en=1, ifid_flush=1, idex_bubble=1, flush_count++.
//  - branch + load_use in the same cycle: branch action only; stall_count unchanged.
//  - load_use: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=1, stall_count++.
//  - The stall lasts exactly 1 cycle; the bubble clears ex_memRead, so load_use cannot re-fire.
//  FSM (rising edge):
//  - RUN: freeze -> MEM_WAIT, wait_cnt=1; otherwise stay in RUN.
//  - MEM_WAIT, freeze still high:
//      wait_cnt==MEM_TIMEOUT-1 -> LOCKED, mem_err=1; otherwise wait_cnt++.
//    LOCKED is therefore entered after exactly MEM_TIMEOUT freeze cycles.
//  - MEM_WAIT, mem_ready=1 or mem_req=0: that cycle behaves as RUN; next state RUN, wait_cnt=0.
//  - LOCKED: all *_en=0; exmem_bubble=0 unless err_clr.
//  - LOCKED with err_clr=1 that cycle:
//      all *_en=1, ifid_flush=idex_bubble=exmem_bubble=1;
//      next state RUN, mem_err=0, wait_cnt=0.
//  - LOCKED is left only via err_clr or rst.
//  Counters:
//  - Increment by 1 per qualifying cycle; saturate at 2^CNT_W-1 (no wrap).
//  - Freeze cycles in LOCKED are not counted.
//  - Reset mid-wait or mid-lock returns to RUN immediately with counters cleared.
// TESTING
//  1 Reset: rst=0 -> all *_en=0, bubbles/flush=1, state=0, counters=0.
//    Release -> all *_en=1 in the next cycle.
//  2 Load-use: ex_memRead=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1;
//    stall_count=1. Same with id_uses_rs=0 -> no stall.
//  3 Same cycle branch_taken=1 and load_use -> ifid_flush=1, idex_bubble=1, pc_en=1;
//    flush_count=1, stall_count=0.
//  4 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> *_en=0 for 3 cycles;
//    state=1 on cycles 2-3; *_en=1 on cycle 4; state=0 after; stall_count=3.
//  5 mem_ready held 0 (MEM_TIMEOUT=8) -> state=2 and mem_err=1 from cycle 9.
//    err_clr pulse -> that cycle all flush/bubbles=1; state=0 and mem_err=0 after.
//  6 CNT_W=4, 20 load-use stalls -> stall_count saturates at 15.
//    rst pulse during MEM_WAIT -> state=0, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the IF/ID, ID/EX and EX/MEM registers of the five-stage core.
// Resolves load-use, taken-branch and data-memory wait hazards, with a lock after a memory timeout.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  err_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  exmem_en,
    output logic                  exmem_bubble,
    output logic                  mem_err,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_memRead & ((id_uses_rs & (id_rs == ex_rd)) |
                                    (id_uses_rt & (id_rt == ex_rd)));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;

        case (state_q)
            S_RUN, S_WAIT: begin
                // A MEM_WAIT cycle whose access completes is handled exactly like RUN.
                if (freeze) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                    if (state_q == S_RUN) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WC_W'(1);
                    end else if (wait_cnt_q == WC_LAST) begin
                        state_d = S_LOCKED;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_cnt_d = sat_inc(flush_cnt_q);
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        stall_cnt_d = sat_inc(stall_cnt_q);
                    end
                end
            end
            S_LOCKED: begin
                if (err_clr) begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    exmem_bubble = 1'b1;
                    state_d      = S_RUN;
                    wait_cnt_d   = '0;
                end else begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Hold the whole pipeline frozen and flushed while reset is asserted.
        if (!rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err     = (state_q == S_LOCKED);
    assign state       = state_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4 so saturation is reachable).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_memRead, branch_taken;
    logic       mem_req, mem_ready, err_clr;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic       exmem_en, exmem_bubble, mem_err;
    logic [1:0] state;
    logic [3:0] stall_count, flush_count;
    logic [6:0] ctl;

    int checks = 0;
    int errors = 0;

    // Expected control patterns: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble}
    localparam logic [6:0] C_RESET  = 7'b0000_111;
    localparam logic [6:0] C_NORMAL = 7'b1111_000;
    localparam logic [6:0] C_LOADUS = 7'b0011_010;
    localparam logic [6:0] C_BRANCH = 7'b1111_110;
    localparam logic [6:0] C_FROZEN = 7'b0000_000;
    localparam logic [6:0] C_ERRCLR = 7'b1111_111;

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .err_clr(err_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .exmem_bubble(exmem_bubble),
        .mem_err(mem_err), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_bubble};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memRead = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        mem_req = 1'b1;
        #2;
        checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL rst_ctl: got %b want %b", ctl, C_RESET); end
        step(); step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (stall_count !== 4'd0 || flush_count !== 4'd0) begin errors++;
            $display("FAIL rst_counts: got %0d/%0d want 0/0", stall_count, flush_count); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        mem_req = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL rel_ctl: got %b want %b", ctl, C_NORMAL); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
        #1;
        checks++; if (ctl !== C_LOADUS) begin errors++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LOADUS); end
        step();
        ex_memRead = 1'b0;
        #1;
        checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_after: got %b want %b", ctl, C_NORMAL); end
        checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count: got %0d want 1", stall_count); end
        ex_memRead = 1'b1; id_uses_rs = 1'b0;
        #1;
        checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_unused_rs: got %b want %b", ctl, C_NORMAL); end
        step();
        ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl !== C_LOADUS) begin errors++; $display("FAIL lu_rt: got %b want %b", ctl, C_LOADUS); end
        step();
        ex_rd = 3'd0; id_rt = 3'd0;
        #1;
        checks++; if (ctl !== C_LOADUS) begin errors++; $display("FAIL lu_r0: got %b want %b", ctl, C_LOADUS); end
        step();
        ex_rd = 3'd7; id_rt = 3'd3;
        #1;
        checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL lu_bit2_diff: got %b want %b", ctl, C_NORMAL); end
        step();
        checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL lu_count3: got %0d want 3", stall_count); end
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 3'd2; id_rs = 3'd2; id_uses_rs = 1'b1; branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL br_ctl: got %b want %b", ctl, C_BRANCH); end
        step();
        clear_inputs();
        checks++; if (flush_count !== 4'd1 || stall_count !== 4'd0) begin errors++;
            $display("FAIL br_counts: got flush=%0d stall=%0d want 1/0", flush_count, stall_count); end
    endtask

    task automatic test_mem_wait();
        logic [1:0] exp_state;
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            exp_state = (c == 1) ? 2'd0 : 2'd1;
            #1;
            checks++; if (ctl !== C_FROZEN) begin errors++; $display("FAIL mw_ctl%0d: got %b want %b", c, ctl, C_FROZEN); end
            checks++; if (state !== exp_state) begin errors++; $display("FAIL mw_state%0d: got %0d want %0d", c, state, exp_state); end
            step();
        end
        branch_taken = 1'b0; mem_ready = 1'b1;
        #1;
        checks++; if (ctl !== C_NORMAL || state !== 2'd1) begin errors++;
            $display("FAIL mw_done: got ctl=%b state=%0d want %b/1", ctl, state, C_NORMAL); end
        step();
        clear_inputs();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mw_back_run: got %0d want 0", state); end
        checks++; if (stall_count !== 4'd3 || flush_count !== 4'd0) begin errors++;
            $display("FAIL mw_counts: got stall=%0d flush=%0d want 3/0", stall_count, flush_count); end
    endtask

    task automatic test_lock();
        logic [1:0] exp_state;
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_state = (c < 8) ? 2'd1 : 2'd2;
            checks++; if (state !== exp_state) begin errors++; $display("FAIL lk_state%0d: got %0d want %0d", c, state, exp_state); end
        end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL lk_mem_err: got %b want 1", mem_err); end
        checks++; if (ctl !== C_FROZEN) begin errors++; $display("FAIL lk_ctl: got %b want %b", ctl, C_FROZEN); end
        step();
        checks++; if (stall_count !== 4'd8) begin errors++; $display("FAIL lk_no_count: got %0d want 8", stall_count); end
        mem_req = 1'b0;
        step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL lk_hold: got %0d want 2", state); end
        err_clr = 1'b1;
        #1;
        checks++; if (ctl !== C_ERRCLR) begin errors++; $display("FAIL lk_clr_ctl: got %b want %b", ctl, C_ERRCLR); end
        step();
        err_clr = 1'b0;
        checks++; if (state !== 2'd0 || mem_err !== 1'b0) begin errors++;
            $display("FAIL lk_cleared: got state=%0d mem_err=%b want 0/0", state, mem_err); end
        checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL lk_resume: got %b want %b", ctl, C_NORMAL); end
        clear_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        ex_memRead = 1'b1; ex_rd = 3'd4; id_rs = 3'd4; id_uses_rs = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 15) begin
                checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d want 15", stall_count); end
            end
        end
        checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_count); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        step(); step(); step();
        checks++; if (state !== 2'd1 || stall_count !== 4'd3) begin errors++;
            $display("FAIL rmw_pre: got state=%0d stall=%0d want 1/3", state, stall_count); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || stall_count !== 4'd0) begin errors++;
            $display("FAIL rmw_async: got state=%0d stall=%0d want 0/0", state, stall_count); end
        checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL rmw_ctl: got %b want %b", ctl, C_RESET); end
        clear_inputs();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_lock();
        test_saturate();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
